// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with shift counter and done pulse
//
// Purpose:
//   WIDTH-bit register supporting hold, shift right, shift left and parallel load.
//   It counts the shifts performed since the last load or reset. The count saturates
//   at WIDTH. done pulses for one cycle when the count first reaches WIDTH.
//
// Optional feature (macro UNIV_SHIFT_REG_ROTATE_EN):
//   This macro adds input rot. When rot=1, shifts become rotates and ignore sr_in/sl_in.
//
// Ports:
//   Clock   in   rising-edge clock
//   Resetn  in   asynchronous active-low reset
//   en      in   clock enable; 0 freezes q/cnt and clears done
//   mode    in   00 hold, 01 shift right, 10 shift left, 11 parallel load
//   sr_in   in   serial bit entering at the MSB on shift right
//   sl_in   in   serial bit entering at the LSB on shift left
//   d       in   parallel load data
//   rot     in   rotate select (only with UNIV_SHIFT_REG_ROTATE_EN)
//   q       out  register contents
//   cnt     out  shifts since last load/reset, saturating at WIDTH
//   done    out  one-cycle pulse after cnt reaches WIDTH
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sr_in,
  input  logic             sl_in,
  input  logic [WIDTH-1:0] d,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [1:0]    MODE_HOLD  = 2'b00;
  localparam logic [1:0]    MODE_SHR   = 2'b01;
  localparam logic [1:0]    MODE_SHL   = 2'b10;
  localparam logic [1:0]    MODE_LOAD  = 2'b11;
  localparam logic [CW-1:0] CNT_MAX    = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PRELAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic             w_shift;
  logic             w_msb_in;
  logic             w_lsb_in;
  logic [WIDTH-1:0] w_q_next;
  logic [CW-1:0]    w_cnt_next;
  logic             w_done_next;

  assign w_shift = en && ((mode == MODE_SHR) || (mode == MODE_SHL));

  // The bits entering on a shift are either the serial inputs or, when rotating,
  // the bit leaving at the opposite end.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
  assign w_msb_in = rot ? r_q[0]       : sr_in;
  assign w_lsb_in = rot ? r_q[WIDTH-1] : sl_in;
`else
  assign w_msb_in = sr_in;
  assign w_lsb_in = sl_in;
`endif

  always_comb begin
    w_q_next    = r_q;
    w_cnt_next  = r_cnt;
    w_done_next = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: begin
          w_q_next = r_q;
        end
        MODE_SHR: begin
          w_q_next = {w_msb_in, r_q[WIDTH-1:1]};
        end
        MODE_SHL: begin
          w_q_next = {r_q[WIDTH-2:0], w_lsb_in};
        end
        MODE_LOAD: begin
          w_q_next   = d;
          w_cnt_next = '0;
        end
        default: begin
          w_q_next = r_q;
        end
      endcase
      if (w_shift) begin
        // The count saturates instead of wrapping. done fires only on the
        // WIDTH-1 -> WIDTH step, so shifts at saturation never re-pulse it.
        if (r_cnt != CNT_MAX) begin
          w_cnt_next = r_cnt + 1'b1;
        end
        w_done_next = (r_cnt == CNT_PRELAST);
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_q    <= RESET_VAL;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_cnt  <= w_cnt_next;
      r_done <= w_done_next;
    end
  end

  assign q    = r_q;
  assign cnt  = r_cnt;
  assign done = r_done;

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 The block SHALL have port Clock  input  1  single clock, all state updates on rising edge.
REQ-004 The block SHALL have port Resetn  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port en  input  1  clock enable; 0 freezes all state.
REQ-006 The block SHALL have port mode  input  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 The block SHALL have port sr_in  input  1  serial bit entering at MSB on shift right.
REQ-008 The block SHALL have port sl_in  input  1  serial bit entering at LSB on shift left.
REQ-009 The block SHALL have port d  input  WIDTH  parallel load data.
REQ-010 The block SHALL have port q  output  WIDTH  register contents, registered.
REQ-011 The block SHALL have port cnt  output  CW = clog2(WIDTH+1)  shifts performed since last load or reset, registered.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse when cnt reaches WIDTH, registered.

Function
REQ-013 With en=1, mode=00, the block SHALL keep q and cnt unchanged and drive done=0.
REQ-014 With en=1, mode=01, the block SHALL update q <= {sr_in, q[WIDTH-1:1]} on the next edge.
REQ-015 With en=1, mode=10, the block SHALL update q <= {q[WIDTH-2:0], sl_in} on the next edge.
REQ-016 With en=1, mode=11, the block SHALL update q <= d, set cnt <= 0, drive done=0 on the next edge.
REQ-017 Each shift (mode 01 or 10) SHALL increment cnt by 1, saturating at WIDTH; no wrap to 0.
REQ-018 done SHALL be 1 for exactly the one cycle following the edge at which cnt transitions WIDTH-1 -> WIDTH, else 0.
REQ-019 Shifts while cnt=WIDTH SHALL still shift q, leave cnt at WIDTH, and SHALL NOT reassert done.
REQ-020 With en=0, q and cnt SHALL hold regardless of mode, sr_in, sl_in, d; done SHALL be 0 on the following cycle.
REQ-021 Latency SHALL be one clock from input sampling to q/cnt/done update; no combinational input-to-output path.
REQ-022 Mixed right and left shifts SHALL both count toward cnt; direction does not matter for cnt/done.

Reset
REQ-023 Resetn=0 SHALL immediately, independent of Clock, set q=RESET_VAL, cnt=0, done=0.
REQ-024 Reset asserted mid-shift sequence SHALL discard the partial count; first edge after Resetn rises performs normal operation per en/mode.
REQ-025 Reset deassertion SHALL be sampled such that no state changes occur on a Clock edge coincident with Resetn still low.

Configuration
REQ-026 Macro UNIV_SHIFT_REG_ROTATE_EN, when defined, SHALL add port rot (input, 1): rot=1 makes mode 01 insert q[0] at MSB and mode 10 insert q[WIDTH-1] at LSB, ignoring sr_in/sl_in; cnt/done behave as for shifts.
REQ-027 Without UNIV_SHIFT_REG_ROTATE_EN, port rot SHALL be absent and shifts SHALL always use sr_in/sl_in.

Verification
REQ-028 WIDTH=8, reset, then Resetn=1 -> q=8'h00, cnt=0, done=0; assert Resetn=0 between edges -> q returns to RESET_VAL immediately.
REQ-029 Load d=8'hA5 (mode 11), then 8 right shifts with sr_in=0 -> q sequence 52,29,14,0A,05,02,01,00; done=1 only the cycle after the 8th shift; cnt=8.
REQ-030 Load 8'h81, 3 left shifts sl_in=1 with en toggled 0 between each -> q=08'h0F after 3 enabled shifts; q/cnt frozen in en=0 cycles; cnt=3, done=0.
REQ-031 After cnt=8, 4 further shifts -> cnt stays 8, done stays 0; then load 8'h3C -> cnt=0, q=3C.
REQ-032 With UNIV_SHIFT_REG_ROTATE_EN, load 8'h81, rot=1, one right shift -> q=8'hC0; one left shift -> q=8'h81; cnt=2.
REQ-033 Reset asserted after 5 shifts -> cnt=0; next 8 shifts -> done pulses once after the 8th.
